// File: rtl/cipher_parallel2serial.sv
// Parallel-to-serial stage of the XOR cipher datapath: captures a word (optionally
// XORed with a key), shifts it out MSB first, with a one-entry pending buffer.
module cipher_parallel2serial #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [N-1:0] a,
    input  logic [N-1:0] key,
    input  logic         enc_en,
    output logic         q,
    output logic         q_valid,
    output logic         conversion_start,
    output logic         conversion_finish,
    output logic         module_busy,
    output logic         overflow
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t        state, state_n;
    logic [N-1:0]  sreg, sreg_n;
    logic [N-1:0]  pend, pend_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          pend_valid, pend_valid_n;
    logic          ovf, ovf_n;
    logic [N-1:0]  cw;

    assign cw = enc_en ? (a ^ key) : a;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            sreg       <= '0;
            cnt        <= '0;
            pend       <= '0;
            pend_valid <= 1'b0;
            ovf        <= 1'b0;
        end else begin
            state      <= state_n;
            sreg       <= sreg_n;
            cnt        <= cnt_n;
            pend       <= pend_n;
            pend_valid <= pend_valid_n;
            ovf        <= ovf_n;
        end
    end

    always_comb begin
        state_n      = state;
        sreg_n       = sreg;
        cnt_n        = cnt;
        pend_n       = pend;
        pend_valid_n = pend_valid;
        ovf_n        = ovf;
        case (state)
            IDLE: begin
                if (load) begin
                    sreg_n  = cw;
                    cnt_n   = '0;
                    state_n = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt != LAST) begin
                    sreg_n = {sreg[N-2:0], 1'b0};
                    cnt_n  = cnt + CW'(1);
                    if (load) begin
                        if (!pend_valid) begin
                            pend_n       = cw;
                            pend_valid_n = 1'b1;
                        end else begin
                            ovf_n = 1'b1;
                        end
                    end
                end else if (pend_valid) begin
                    // Pending word goes out next; a same-cycle load refills the slot.
                    sreg_n = pend;
                    cnt_n  = '0;
                    if (load) pend_n = cw;
                    else      pend_valid_n = 1'b0;
                end else if (load) begin
                    sreg_n = cw;
                    cnt_n  = '0;
                end else begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign q_valid           = (state == SHIFT);
    assign q                 = q_valid & sreg[N-1];
    assign conversion_start  = q_valid & (cnt == '0);
    assign conversion_finish = q_valid & (cnt == LAST);
    assign module_busy       = q_valid | pend_valid;
    assign overflow          = ovf;

endmodule
